decode_queue: RTL and testbench

//  Multi-wide decode buffer between fetch and dispatch. Accepts up to FETCH_W

---
 rtl/decode_queue_if.sv | 36 +++
 rtl/decode_queue.sv | 147 ++++++++++++++
 tb/tb_decode_queue.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch/dispatch side bundle for decode_queue.
//   master : fetch + dispatch agent (drives in_*, disp_take)
//   slave  : the decode queue (drives in_ready, out_*, count)
// Signals:
//   in_valid/in_inst/in_pc  per-lane offer from fetch, valid lanes contiguous from lane 0
//   in_ready                all offered lanes are accepted this cycle
//   out_valid/out_inst/out_pc/out_fu/out_illegal  oldest DISP_W entries, lane 0 oldest
//   disp_take               number of entries dispatch retires this cycle
//   count                   occupancy
interface decode_queue_if #(
    parameter int FETCH_W = 2,
    parameter int DISP_W  = 2,
    parameter int DEPTH   = 8
);
    logic [FETCH_W-1:0]                in_valid;
    logic [FETCH_W-1:0][31:0]          in_inst;
    logic [FETCH_W-1:0][31:0]          in_pc;
    logic                              in_ready;
    logic [DISP_W-1:0]                 out_valid;
    logic [DISP_W-1:0][31:0]           out_inst;
    logic [DISP_W-1:0][31:0]           out_pc;
    logic [DISP_W-1:0][2:0]            out_fu;
    logic [DISP_W-1:0]                 out_illegal;
    logic [$clog2(DISP_W+1)-1:0]       disp_take;
    logic [$clog2(DEPTH+1)-1:0]        count;

    modport master (
        output in_valid, in_inst, in_pc, disp_take,
        input  in_ready, out_valid, out_inst, out_pc, out_fu, out_illegal, count
    );

    modport slave (
        input  in_valid, in_inst, in_pc, disp_take,
        output in_ready, out_valid, out_inst, out_pc, out_fu, out_illegal, count
    );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: multi-wide decode buffer between fetch and dispatch.
// Classifies each accepted instruction into a 3-bit FU class at enqueue and
// holds the results in a DEPTH-entry circular FIFO. The oldest DISP_W entries
// are presented to dispatch, which retires an in-order prefix each cycle.
// Ports:
//   clock   single clock, posedge
//   reset   synchronous, active-high
//   squash  synchronous flush, same effect as reset
//   q       decode_queue_if slave modport (fetch offer, dispatch view, count)
module decode_queue #(
    parameter int FETCH_W = 2,
    parameter int DISP_W  = 2,
    parameter int DEPTH   = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          squash,
    decode_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] FU_ALU = 3'b000;
    localparam logic [2:0] FU_MUL = 3'b001;
    localparam logic [2:0] FU_LSU = 3'b011;
    localparam logic [2:0] FU_CTL = 3'b100;
    localparam logic [2:0] FU_ILL = 3'b111;

    // Pure function of the instruction word; anything not listed is illegal.
    function automatic logic [2:0] classify(input logic [31:0] w);
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [2:0] c;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        c  = FU_ILL;
        case (op)
            7'b0110011: begin
                if (f7 == 7'b0000000)
                    c = FU_ALU;
                else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                    c = FU_ALU;
                else if (f7 == 7'b0000001 && f3[2] == 1'b0)
                    c = FU_MUL;
            end
            7'b0010011: begin
                // Shift-immediates constrain the upper bits; the rest take any immediate.
                if (f3 == 3'b001) begin
                    if (f7 == 7'b0000000) c = FU_ALU;
                end else if (f3 == 3'b101) begin
                    if (f7 == 7'b0000000 || f7 == 7'b0100000) c = FU_ALU;
                end else begin
                    c = FU_ALU;
                end
            end
            7'b0000011: begin
                if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                    f3 == 3'b100 || f3 == 3'b101)
                    c = FU_LSU;
            end
            7'b0100011: begin
                if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010)
                    c = FU_LSU;
            end
            7'b0110111, 7'b0010111, 7'b1101111: c = FU_CTL;
            7'b1100111: begin
                if (f3 == 3'b000) c = FU_CTL;
            end
            7'b1100011: begin
                if (f3 != 3'b010 && f3 != 3'b011) c = FU_CTL;
            end
            7'b1110011: begin
                if (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011 || w == 32'h1050_0073)
                    c = FU_CTL;
            end
            default: c = FU_ILL;
        endcase
        return c;
    endfunction

    logic [31:0]   inst_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [2:0]    fu_q   [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;

    logic          ready;
    logic [CW-1:0] enq;
    logic [CW-1:0] deq;
    logic [CW-1:0] avail;
    logic [CW-1:0] take;
    logic [PW-1:0] wr_idx [FETCH_W];
    logic [PW-1:0] rd_idx [DISP_W];

    always_comb begin
        // Registered count only: a same-cycle dequeue never opens the door.
        ready = (count_q <= CW'(DEPTH - FETCH_W));
        enq   = '0;
        if (ready) begin
            for (int i = 0; i < FETCH_W; i++) begin
                if (q.in_valid[i]) enq = enq + CW'(1);
            end
        end
        avail = (count_q > CW'(DISP_W)) ? CW'(DISP_W) : count_q;
        take  = CW'(q.disp_take);
        // Over-asking dispatch is clamped to what is actually visible.
        deq   = (take > avail) ? avail : take;
        for (int i = 0; i < FETCH_W; i++) wr_idx[i] = tail_q + PW'(i);
        for (int i = 0; i < DISP_W; i++)  rd_idx[i] = head_q + PW'(i);
    end

    always_ff @(posedge clock) begin
        if (reset || squash) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < FETCH_W; i++) begin
                if (CW'(i) < enq) begin
                    inst_q[wr_idx[i]] <= q.in_inst[i];
                    pc_q[wr_idx[i]]   <= q.in_pc[i];
                    fu_q[wr_idx[i]]   <= classify(q.in_inst[i]);
                end
            end
            head_q  <= head_q + PW'(deq);
            tail_q  <= tail_q + PW'(enq);
            count_q <= count_q + enq - deq;
        end
    end

    always_comb begin
        for (int i = 0; i < DISP_W; i++) begin
            q.out_valid[i]   = (count_q > CW'(i));
            q.out_inst[i]    = inst_q[rd_idx[i]];
            q.out_pc[i]      = pc_q[rd_idx[i]];
            q.out_fu[i]      = fu_q[rd_idx[i]];
            // Storage is never cleared, so gate the flag to keep empty lanes quiet.
            q.out_illegal[i] = (count_q > CW'(i)) && (fu_q[rd_idx[i]] == FU_ILL);
        end
    end

    assign q.in_ready = ready;
    assign q.count    = count_q;
endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;
    localparam int FW = 2;
    localparam int DW = 2;
    localparam int DP = 8;

    localparam logic [31:0] I_ADD   = 32'h0031_00B3;
    localparam logic [31:0] I_MUL   = 32'h0231_00B3;
    localparam logic [31:0] I_LW    = 32'h0001_2083;
    localparam logic [31:0] I_ZERO  = 32'h0000_0000;
    localparam logic [31:0] I_LUI   = 32'h1234_50B7;
    localparam logic [31:0] I_BEQ   = 32'h0020_8063;
    localparam logic [31:0] I_CSRRW = 32'h3001_10F3;
    localparam logic [31:0] I_WFI   = 32'h1050_0073;
    localparam logic [31:0] I_SRAI  = 32'h4031_5093;
    localparam logic [31:0] I_MULHU = 32'h0231_30B3;
    localparam logic [31:0] I_SB    = 32'h0031_0023;
    localparam logic [31:0] I_SLTIU = 32'h0051_3093;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic squash = 1'b0;
    always #5 clock = ~clock;

    decode_queue_if #(.FETCH_W(FW), .DISP_W(DW), .DEPTH(DP)) bus ();

    decode_queue #(.FETCH_W(FW), .DISP_W(DW), .DEPTH(DP)) dut (
        .clock (clock),
        .reset (reset),
        .squash(squash),
        .q     (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [2:0]  fu;
        logic        ill;
    } ent_t;

    ent_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] pc_gen = '0;

    function automatic ent_t lane(input int l);
        ent_t e;
        e.pc   = bus.out_pc[l];
        e.inst = bus.out_inst[l];
        e.fu   = bus.out_fu[l];
        e.ill  = bus.out_illegal[l];
        return e;
    endfunction

    // One clock of stimulus; the scoreboard follows the accept/retire rules.
    task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [2:0] f0,
                         input logic [31:0] i1, input logic [2:0] f1,
                         input logic [1:0] take, input logic sq);
        bit acc;
        int nv;
        bus.in_valid   = v;
        bus.in_inst[0] = i0;
        bus.in_inst[1] = i1;
        bus.in_pc[0]   = pc_gen;
        bus.in_pc[1]   = pc_gen + 32'd4;
        bus.disp_take  = take;
        squash         = sq;
        nv  = $countones(bus.out_valid);
        acc = (DP - sb.size()) >= FW;
        assert (v != 2'b10) else $error("FAIL proto_valid in_valid=%b", v);
        assert (int'(take) <= nv) else $error("FAIL proto_take take=%0d visible=%0d", take, nv);
        @(posedge clock);
        if (sq) begin
            sb.delete();
        end else begin
            for (int k = 0; k < int'(take); k++) if (sb.size() > 0) void'(sb.pop_front());
            if (acc) begin
                if (v[0]) sb.push_back('{pc: pc_gen, inst: i0, fu: f0, ill: (f0 == 3'b111)});
                if (v[1]) sb.push_back('{pc: pc_gen + 32'd4, inst: i1, fu: f1, ill: (f1 == 3'b111)});
                pc_gen = pc_gen + 32'(4 * $countones(v));
            end
        end
        #1;
        bus.in_valid  = '0;
        bus.disp_take = '0;
        squash        = 1'b0;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.in_valid   = 2'b11;
        bus.in_inst[0] = I_ADD;
        bus.in_inst[1] = I_MUL;
        bus.disp_take  = '0;
        @(posedge clock);
        #1;
        reset        = 1'b0;
        bus.in_valid = '0;
        sb.delete();
        pc_gen = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 2'b00) begin errors++; $display("FAIL rst_out_valid got=%b exp=00", bus.out_valid); end
        checks++; if (bus.out_illegal !== 2'b00) begin errors++; $display("FAIL rst_illegal got=%b exp=00", bus.out_illegal); end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
    endtask

    task automatic test_basic();
        do_reset();
        drive(2'b11, I_ADD, 3'b000, I_MUL, 3'b001, 2'd0, 1'b0);
        checks++; if (bus.out_valid !== 2'b11) begin errors++; $display("FAIL basic_valid got=%b exp=11", bus.out_valid); end
        checks++; if (bus.out_fu !== {3'b001, 3'b000}) begin errors++; $display("FAIL basic_fu got=%b exp=001000", bus.out_fu); end
        checks++; if (bus.count !== 4'd2) begin errors++; $display("FAIL basic_count got=%0d exp=2", bus.count); end
        for (int l = 0; l < DW; l++) begin
            checks++;
            if (lane(l) !== sb[l]) begin errors++; $display("FAIL basic_lane%0d got=%h exp=%h", l, lane(l), sb[l]); end
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int n = 0; n < 5; n++) begin
            checks++;
            if (bus.in_ready !== (n < 4)) begin errors++; $display("FAIL fill_ready n=%0d got=%b exp=%b", n, bus.in_ready, (n < 4)); end
            drive(2'b11, I_ADD, 3'b000, I_MUL, 3'b001, 2'd0, 1'b0);
            checks++;
            if (bus.count !== 4'((n < 4) ? 2 * (n + 1) : 8)) begin
                errors++; $display("FAIL fill_count n=%0d got=%0d exp=%0d", n, bus.count, (n < 4) ? 2 * (n + 1) : 8);
            end
        end
        // count 8 -> 7 with an offer pending: still not ready, offer dropped
        drive(2'b11, I_LW, 3'b011, I_LW, 3'b011, 2'd1, 1'b0);
        checks++; if (bus.count !== 4'd7) begin errors++; $display("FAIL fill_count7 got=%0d exp=7", bus.count); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready7 got=%b exp=0", bus.in_ready); end
        drive(2'b11, I_LW, 3'b011, I_LW, 3'b011, 2'd1, 1'b0);
        checks++; if (bus.count !== 4'd6) begin errors++; $display("FAIL fill_count6 got=%0d exp=6", bus.count); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready6 got=%b exp=1", bus.in_ready); end
        for (int l = 0; l < DW; l++) begin
            checks++;
            if (lane(l) !== sb[l]) begin errors++; $display("FAIL fill_lane%0d got=%h exp=%h", l, lane(l), sb[l]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] last_pc;
        bit          first;
        do_reset();
        drive(2'b11, I_ADD, 3'b000, I_MUL, 3'b001, 2'd0, 1'b0);
        drive(2'b11, I_ADD, 3'b000, I_MUL, 3'b001, 2'd0, 1'b0);
        first   = 1'b1;
        last_pc = '0;
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (bus.count !== 4'd4) begin errors++; $display("FAIL b2b_count c=%0d got=%0d exp=4", c, bus.count); end
            for (int l = 0; l < DW; l++) begin
                checks++;
                if (lane(l) !== sb[l]) begin errors++; $display("FAIL b2b_lane%0d c=%0d got=%h exp=%h", l, c, lane(l), sb[l]); end
            end
            checks++;
            if ((!first && bus.out_pc[0] <= last_pc) || bus.out_pc[1] <= bus.out_pc[0]) begin
                errors++; $display("FAIL b2b_order c=%0d got=%h,%h last=%h", c, bus.out_pc[0], bus.out_pc[1], last_pc);
            end
            first   = 1'b0;
            last_pc = bus.out_pc[1];
            drive(2'b11, I_ADD, 3'b000, I_MUL, 3'b001, 2'd2, 1'b0);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        drive(2'b11, I_ZERO, 3'b111, I_LW, 3'b011, 2'd0, 1'b0);
        checks++; if (bus.out_fu !== {3'b011, 3'b111}) begin errors++; $display("FAIL ill_fu got=%b exp=011111", bus.out_fu); end
        checks++; if (bus.out_illegal !== 2'b01) begin errors++; $display("FAIL ill_flag got=%b exp=01", bus.out_illegal); end
        drive(2'b00, I_ZERO, 3'b111, I_ZERO, 3'b111, 2'd1, 1'b0);
        checks++; if (bus.out_valid !== 2'b01) begin errors++; $display("FAIL ill_valid_after got=%b exp=01", bus.out_valid); end
        checks++; if (bus.out_illegal !== 2'b00) begin errors++; $display("FAIL ill_flag_after got=%b exp=00", bus.out_illegal); end
        checks++; if (lane(0) !== sb[0]) begin errors++; $display("FAIL ill_lane0 got=%h exp=%h", lane(0), sb[0]); end
    endtask

    task automatic test_squash_wrap();
        do_reset();
        for (int n = 0; n < 3; n++) drive(2'b11, I_ADD, 3'b000, I_SB, 3'b011, 2'd0, 1'b0);
        for (int n = 0; n < 3; n++) drive(2'b00, I_ADD, 3'b000, I_ADD, 3'b000, 2'd2, 1'b0);
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL sq_drain got=%0d exp=0", bus.count); end
        for (int n = 0; n < 3; n++) drive(2'b11, I_LUI, 3'b100, I_MULHU, 3'b001, 2'd0, 1'b0);
        checks++; if (bus.count !== 4'd6) begin errors++; $display("FAIL sq_refill got=%0d exp=6", bus.count); end
        for (int l = 0; l < DW; l++) begin
            checks++;
            if (lane(l) !== sb[l]) begin errors++; $display("FAIL sq_lane%0d got=%h exp=%h", l, lane(l), sb[l]); end
        end
        drive(2'b11, I_ADD, 3'b000, I_MUL, 3'b001, 2'd1, 1'b1);
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL sq_count got=%0d exp=0", bus.count); end
        checks++; if (bus.out_valid !== 2'b00) begin errors++; $display("FAIL sq_valid got=%b exp=00", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL sq_ready got=%b exp=1", bus.in_ready); end
        drive(2'b01, I_SLTIU, 3'b000, I_ZERO, 3'b111, 2'd0, 1'b0);
        checks++; if (bus.out_valid !== 2'b01) begin errors++; $display("FAIL sq_post_valid got=%b exp=01", bus.out_valid); end
        checks++; if (lane(0) !== sb[0]) begin errors++; $display("FAIL sq_post_lane0 got=%h exp=%h", lane(0), sb[0]); end
    endtask

    task automatic test_class_sweep();
        logic [31:0] sw_inst [8];
        logic [2:0]  sw_fu   [8];
        sw_inst = '{I_LUI, I_BEQ, I_CSRRW, I_WFI, I_SRAI, I_MULHU, I_SB, I_SLTIU};
        sw_fu   = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b001, 3'b011, 3'b000};
        do_reset();
        for (int c = 0; c < 4; c++)
            drive(2'b11, sw_inst[2*c], sw_fu[2*c], sw_inst[2*c+1], sw_fu[2*c+1], 2'd0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            for (int l = 0; l < DW; l++) begin
                checks++;
                if (bus.out_fu[l] !== sw_fu[2*c+l] || lane(l) !== sb[l]) begin
                    errors++; $display("FAIL sweep_%0d got_fu=%b exp_fu=%b got=%h exp=%h", 2*c+l, bus.out_fu[l], sw_fu[2*c+l], lane(l), sb[l]);
                end
            end
            drive(2'b00, I_ZERO, 3'b111, I_ZERO, 3'b111, 2'd2, 1'b0);
        end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL sweep_empty got=%0d exp=0", bus.count); end
    endtask

    initial begin
        bus.in_valid  = '0;
        bus.in_inst   = '0;
        bus.in_pc     = '0;
        bus.disp_take = '0;
        test_reset();
        test_basic();
        test_fill();
        test_back_to_back();
        test_illegal();
        test_squash_wrap();
        test_class_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
